// File: rtl/traffic_light_monitor.sv
// Safety monitor for a four-direction traffic light controller: checks lamp legality,
// sequencing, yellow duration and liveness, latching the first fault seen after arming.
module traffic_light_monitor #(
    parameter int unsigned YELLOW_MIN = 4,
    parameter int unsigned WDOG_MAX   = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LED_RED_1,
    input  logic       LED_RED_2,
    input  logic       LED_RED_3,
    input  logic       LED_RED_4,
    input  logic       LED_GREEN_1,
    input  logic       LED_GREEN_2,
    input  logic       LED_GREEN_3,
    input  logic       LED_GREEN_4,
    input  logic       LED_YELLOW_1,
    input  logic       LED_YELLOW_2,
    input  logic       LED_YELLOW_3,
    input  logic       LED_YELLOW_4,
    input  logic       i_clear,
    output logic       o_armed,
    output logic       o_fault,
    output logic [2:0] o_fault_code,
    output logic [1:0] o_fault_dir,
    output logic [1:0] o_active_dir,
    output logic [7:0] o_green_count
);
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_ILLEGAL  = 3'd2;
    localparam logic [2:0] C_BADSEQ   = 3'd3;
    localparam logic [2:0] C_SHORTY   = 3'd4;
    localparam logic [2:0] C_STUCK    = 3'd5;

    logic [3:0] w_r, w_g, w_y, w_gy;
    assign w_r  = {LED_RED_4, LED_RED_3, LED_RED_2, LED_RED_1};
    assign w_g  = {LED_GREEN_4, LED_GREEN_3, LED_GREEN_2, LED_GREEN_1};
    assign w_y  = {LED_YELLOW_4, LED_YELLOW_3, LED_YELLOW_2, LED_YELLOW_1};
    assign w_gy = w_g | w_y;

    logic            r_armed, r_fault;
    logic [2:0]      r_code;
    logic [1:0]      r_fdir, r_active;
    logic [7:0]      r_green;
    logic [15:0]     r_wdog;
    logic [3:0]      r_pr, r_pg, r_py;
    logic [3:0][7:0] r_ycnt;

    logic [3:0]      w_legal, w_pleg, w_chg, w_bad, w_r2g, w_short;
    logic [3:0][7:0] w_ycnt_nxt;
    logic [2:0]      w_r2g_cnt;
    logic [1:0]      w_act_dir;
    logic            w_conflict, w_any_chg, w_stuck;
    logic [15:0]     w_wdog_nxt;
    logic            w_new_fault;
    logic [2:0]      w_new_code;
    logic [1:0]      w_new_dir;

    // Transition checks only apply when both the previous and current lamp states are legal.
    always_comb begin
        w_r2g_cnt = 3'd0;
        for (int d = 0; d < 4; d++) begin
            w_legal[d] = (w_r[d] & ~w_g[d] & ~w_y[d]) | (~w_r[d] & w_g[d] & ~w_y[d]) |
                         (~w_r[d] & ~w_g[d] & w_y[d]);
            w_pleg[d]  = (r_pr[d] & ~r_pg[d] & ~r_py[d]) | (~r_pr[d] & r_pg[d] & ~r_py[d]) |
                         (~r_pr[d] & ~r_pg[d] & r_py[d]);
            w_chg[d]   = (w_r[d] != r_pr[d]) | (w_g[d] != r_pg[d]) | (w_y[d] != r_py[d]);
            w_bad[d]   = w_legal[d] & w_pleg[d] &
                         ((r_pg[d] & w_r[d]) | (r_pr[d] & w_y[d]) | (r_py[d] & w_g[d]));
            w_r2g[d]   = w_legal[d] & w_pleg[d] & r_pr[d] & w_g[d];
            w_short[d] = w_legal[d] & w_pleg[d] & r_py[d] & w_r[d] &
                         (32'(r_ycnt[d]) < YELLOW_MIN);
            w_ycnt_nxt[d] = r_ycnt[d];
            if (w_legal[d] && w_y[d]) begin
                if (!(w_pleg[d] && r_py[d]))  w_ycnt_nxt[d] = 8'd1;
                else if (r_ycnt[d] != 8'hFF)  w_ycnt_nxt[d] = r_ycnt[d] + 8'd1;
            end
            w_r2g_cnt = w_r2g_cnt + {2'b00, w_r2g[d]};
        end
    end

    always_comb begin
        w_act_dir = r_active;
        for (int d = 3; d >= 0; d--)
            if (w_gy[d]) w_act_dir = 2'(d);
    end

    assign w_conflict = (w_gy & (w_gy - 4'd1)) != 4'd0;
    assign w_any_chg  = |w_chg;
    assign w_stuck    = (WDOG_MAX != 0) && !w_any_chg && ((32'(r_wdog) + 32'd1) == WDOG_MAX);

    always_comb begin
        w_wdog_nxt = r_wdog;
        if (w_any_chg)               w_wdog_nxt = 16'd0;
        else if (r_wdog != 16'hFFFF) w_wdog_nxt = r_wdog + 16'd1;
    end

    // Later assignments override earlier ones, so lowest code / lowest direction wins.
    always_comb begin
        w_new_fault = 1'b0;
        w_new_code  = 3'd0;
        w_new_dir   = 2'd0;
        if (w_stuck) begin
            w_new_fault = 1'b1; w_new_code = C_STUCK; w_new_dir = 2'd0;
        end
        for (int d = 3; d >= 0; d--)
            if (w_short[d]) begin w_new_fault = 1'b1; w_new_code = C_SHORTY; w_new_dir = 2'(d); end
        for (int d = 3; d >= 0; d--)
            if (w_bad[d]) begin w_new_fault = 1'b1; w_new_code = C_BADSEQ; w_new_dir = 2'(d); end
        for (int d = 3; d >= 0; d--)
            if (!w_legal[d]) begin w_new_fault = 1'b1; w_new_code = C_ILLEGAL; w_new_dir = 2'(d); end
        if (w_conflict) begin
            w_new_fault = 1'b1; w_new_code = C_CONFLICT;
            for (int d = 3; d >= 0; d--)
                if (w_gy[d]) w_new_dir = 2'(d);
        end
        if (!r_armed) w_new_fault = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed  <= 1'b0;
            r_fault  <= 1'b0;
            r_code   <= 3'd0;
            r_fdir   <= 2'd0;
            r_active <= 2'd0;
            r_green  <= 8'd0;
            r_wdog   <= 16'd0;
            r_pr     <= 4'hF;
            r_pg     <= 4'h0;
            r_py     <= 4'h0;
            r_ycnt   <= '0;
        end else begin
            r_pr <= w_r;
            r_pg <= w_g;
            r_py <= w_y;
            if (!r_armed) begin
                if (&w_legal) r_armed <= 1'b1;
            end else begin
                r_ycnt   <= w_ycnt_nxt;
                r_green  <= r_green + {5'd0, w_r2g_cnt};
                r_active <= w_act_dir;
                r_wdog   <= i_clear ? 16'd0 : w_wdog_nxt;
            end
            // A fault detected on the clearing edge takes precedence over the clear.
            if (w_new_fault && (!r_fault || i_clear)) begin
                r_fault <= 1'b1;
                r_code  <= w_new_code;
                r_fdir  <= w_new_dir;
            end else if (i_clear) begin
                r_fault <= 1'b0;
                r_code  <= 3'd0;
                r_fdir  <= 2'd0;
            end
        end
    end

    assign o_armed       = r_armed;
    assign o_fault       = r_fault;
    assign o_fault_code  = r_code;
    assign o_fault_dir   = r_fdir;
    assign o_active_dir  = r_active;
    assign o_green_count = r_green;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal cycling, each fault class, clear, wrap and reset.
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lr, lg, ly;
    logic       i_clear;
    logic       o_armed, o_fault;
    logic [2:0] o_fault_code;
    logic [1:0] o_fault_dir, o_active_dir;
    logic [7:0] o_green_count;
    int         n_pass = 0;
    int         n_total = 0;

    traffic_light_monitor #(.YELLOW_MIN(4), .WDOG_MAX(200)) dut (
        .clk(clk), .rst_n(rst_n),
        .LED_RED_1(lr[0]), .LED_RED_2(lr[1]), .LED_RED_3(lr[2]), .LED_RED_4(lr[3]),
        .LED_GREEN_1(lg[0]), .LED_GREEN_2(lg[1]), .LED_GREEN_3(lg[2]), .LED_GREEN_4(lg[3]),
        .LED_YELLOW_1(ly[0]), .LED_YELLOW_2(ly[1]), .LED_YELLOW_3(ly[2]), .LED_YELLOW_4(ly[3]),
        .i_clear(i_clear), .o_armed(o_armed), .o_fault(o_fault),
        .o_fault_code(o_fault_code), .o_fault_dir(o_fault_dir),
        .o_active_dir(o_active_dir), .o_green_count(o_green_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [3:0] y);
        lr = r; lg = g; ly = y;
        @(posedge clk);
        #1;
    endtask

    task automatic all_red();
        step(4'hF, 4'h0, 4'h0);
    endtask

    task automatic show_g(input int d);
        logic [3:0] m;
        m = 4'(1 << d);
        step(~m, m, 4'h0);
    endtask

    task automatic show_y(input int d);
        logic [3:0] m;
        m = 4'(1 << d);
        step(~m, 4'h0, m);
    endtask

    task automatic chk_fault(input string tag, input logic f, input logic [2:0] c, input logic [1:0] d);
        chk({tag, "_fault"}, 16'(o_fault), 16'(f));
        chk({tag, "_code"}, 16'(o_fault_code), 16'(c));
        chk({tag, "_dir"}, 16'(o_fault_dir), 16'(d));
    endtask

    initial begin
        rst_n = 1'b0; i_clear = 1'b0; lr = 4'h0; lg = 4'h0; ly = 4'h0;
        #12;
        chk("rst_armed", 16'(o_armed), 16'd0);
        chk_fault("rst", 1'b0, 3'd0, 2'd0);
        chk("rst_active", 16'(o_active_dir), 16'd0);
        chk("rst_green", 16'(o_green_count), 16'd0);
        rst_n = 1'b1;

        repeat (5) step(4'h0, 4'h0, 4'h0);
        chk("dark_armed", 16'(o_armed), 16'd0);
        chk("dark_fault", 16'(o_fault), 16'd0);
        all_red();
        chk("arm", 16'(o_armed), 16'd1);

        // Two full legal rounds over all four directions
        for (int p = 0; p < 2; p++)
            for (int d = 0; d < 4; d++) begin
                show_g(d);
                chk("legal_active", 16'(o_active_dir), 16'(d));
                repeat (9) show_g(d);
                repeat (4) show_y(d);
            end
        all_red();
        chk("legal_fault", 16'(o_fault), 16'd0);
        chk("legal_green", 16'(o_green_count), 16'd8);
        chk("legal_hold_active", 16'(o_active_dir), 16'd3);

        repeat (3) show_g(1);
        repeat (2) show_y(1);
        all_red();
        chk_fault("shorty", 1'b1, 3'd4, 2'd1);

        i_clear = 1'b1; all_red(); i_clear = 1'b0;
        chk_fault("clear1", 1'b0, 3'd0, 2'd0);

        repeat (3) show_g(1);
        repeat (4) show_y(1);
        all_red();
        chk("okyellow_fault", 16'(o_fault), 16'd0);

        step(4'b1010, 4'b0101, 4'b0000);
        chk_fault("conflict", 1'b1, 3'd1, 2'd0);
        chk("dual_green", 16'(o_green_count), 16'd12);
        step(4'b1110, 4'b0000, 4'b0001);
        all_red();
        chk_fault("sticky", 1'b1, 3'd1, 2'd0);
        i_clear = 1'b1; all_red(); i_clear = 1'b0;
        chk("clear2", 16'(o_fault), 16'd0);

        show_g(3);
        all_red();
        chk_fault("badseq", 1'b1, 3'd3, 2'd3);
        i_clear = 1'b1; all_red(); i_clear = 1'b0;
        show_g(3);
        step(4'b1111, 4'b0000, 4'b0001);
        chk_fault("illegal_wins", 1'b1, 3'd2, 2'd0);
        i_clear = 1'b1; all_red(); i_clear = 1'b0;
        chk("clear3", 16'(o_fault), 16'd0);

        // 14 transitions so far; 242 more wraps the counter to zero
        for (int k = 0; k < 242; k++) begin
            show_g(0);
            repeat (4) show_y(0);
            all_red();
        end
        chk("wrap_green", 16'(o_green_count), 16'd0);
        chk("wrap_fault", 16'(o_fault), 16'd0);
        chk("wrap_active", 16'(o_active_dir), 16'd0);

        repeat (199) all_red();
        chk("stuck_199", 16'(o_fault), 16'd0);
        all_red();
        chk_fault("stuck_200", 1'b1, 3'd5, 2'd0);
        i_clear = 1'b1; all_red(); i_clear = 1'b0;
        chk("stuck_clear", 16'(o_fault), 16'd0);
        repeat (199) all_red();
        chk("restuck_199", 16'(o_fault), 16'd0);
        all_red();
        chk_fault("restuck_200", 1'b1, 3'd5, 2'd0);

        #2 rst_n = 1'b0;
        #1;
        chk("async_armed", 16'(o_armed), 16'd0);
        chk_fault("async", 1'b0, 3'd0, 2'd0);
        chk("async_active", 16'(o_active_dir), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step(4'h0, 4'h0, 4'h0);
        chk("rearm_dark", 16'(o_armed), 16'd0);
        all_red();
        chk("rearm", 16'(o_armed), 16'd1);
        chk("rearm_green", 16'(o_green_count), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
